// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle shifter (SLL/SRL/SRA/ROL) applying up to STEP positions per cycle
module iter_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [SHAMT_W:0] STEP_V = (SHAMT_W+1)'(STEP);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [1:0]         op_q, op_d;
    logic               sign_q, sign_d;

    logic [SHAMT_W:0]     k;
    logic [SHAMT_W-1:0]   rem_next;
    logic [2*WIDTH-1:0]   dbl_rol, dbl_sr;
    logic [WIDTH-1:0]     shifted;
    logic                 fill;

    // k never exceeds rem, so its low SHAMT_W bits carry the full value
    assign k        = ({1'b0, rem_q} < STEP_V) ? {1'b0, rem_q} : STEP_V;
    assign rem_next = rem_q - k[SHAMT_W-1:0];
    assign fill     = (op_q == OP_SRA) ? sign_q : 1'b0;
    assign dbl_rol  = {work_q, work_q} << k;
    assign dbl_sr   = {{WIDTH{fill}}, work_q} >> k;

    always_comb begin
        shifted = dbl_rol[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_SLL:  shifted = work_q << k;
            OP_SRL,
            OP_SRA:  shifted = dbl_sr[WIDTH-1:0];
            default: shifted = dbl_rol[2*WIDTH-1:WIDTH];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = (in_shamt != '0) ? S_SHIFT : S_DONE;
            S_SHIFT: if (rem_next == '0) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        out_data  = out_data_q;
    end

    always_comb begin
        work_d     = work_q;
        rem_d      = rem_q;
        op_d       = op_q;
        sign_d     = sign_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                work_d = in_data;
                rem_d  = in_shamt;
                op_d   = in_op;
                sign_d = in_data[WIDTH-1];
                if (in_shamt == '0) out_data_d = in_data;
            end
            S_SHIFT: begin
                work_d = shifted;
                rem_d  = rem_next;
                if (rem_next == '0) out_data_d = shifted;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q     <= '0;
            rem_q      <= '0;
            op_q       <= OP_SLL;
            sign_q     <= 1'b0;
            out_data_q <= '0;
        end else begin
            work_q     <= work_d;
            rem_q      <= rem_d;
            op_q       <= op_d;
            sign_q     <= sign_d;
            out_data_q <= out_data_d;
        end
    end
endmodule

// File: doc/iter_shifter.md
ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal range 2..64.
REQ-002 Parameter SHAMT_W, default 5, shift-amount width; SHALL satisfy 2^SHAMT_W >= WIDTH.
REQ-003 Parameter STEP, default 4, maximum bit positions shifted per cycle; legal range 1..WIDTH.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  request present on in_data, in_shamt and in_op.
REQ-007 in_ready  output  1  block accepts a request this cycle.
REQ-008 in_data  input  WIDTH  operand.
REQ-009 in_shamt  input  SHAMT_W  shift amount, unsigned.
REQ-010 in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left).
REQ-011 out_valid  output  1  result present on out_data.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 out_data  output  WIDTH  registered result.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, decoded from state with no combinational path from any input.
REQ-016 Accept SHALL occur at the rising edge where in_valid=1 and in_ready=1; the block SHALL latch the operand, op and remaining count rem=in_shamt.
- Next state is SHIFT if in_shamt!=0, otherwise DONE.
REQ-017 In SHIFT, each edge SHALL apply k=min(STEP, rem) positions to the working register and decrement rem by k.
- The FSM SHALL move to DONE on the edge at which rem reaches 0.
REQ-018 Latency: with N=ceil(in_shamt/STEP) and accept at edge t, out_valid SHALL be 1 from edge t+N onward; N=0 for in_shamt=0.
REQ-019 Fill rules:
- SLL fills zeros at the LSBs.
- SRL fills zeros at the MSBs.
- SRA replicates the operand MSB latched at accept.
- ROL feeds the bits shifted out of the MSB back into the LSBs.
REQ-020 in_shamt >= WIDTH:
- SLL and SRL SHALL return 0.
- SRA SHALL return all bits equal to the sign bit.
- ROL SHALL return the operand rotated by in_shamt mod WIDTH.
- Latency SHALL still follow REQ-018.
REQ-021 In DONE, out_valid=1 and out_data SHALL be held stable until an edge with out_ready=1, which SHALL return the FSM to IDLE with out_valid=0.
REQ-022 A request SHALL NOT be accepted in the same cycle a result is consumed; the earliest next accept is the cycle after return to IDLE.
REQ-023 out_data SHALL keep its last value outside DONE.
- in_data, in_shamt and in_op SHALL be ignored outside the accept edge.
REQ-024 All arithmetic SHALL be width-exact at WIDTH bits; no bit beyond WIDTH-1 SHALL affect the result.

Reset
REQ-025 While rst_n=0, independent of clk, the block SHALL hold:
- state IDLE.
- in_ready=1.
- out_valid=0.
- out_data=0.
- rem=0.
- working register=0.
REQ-026 Reset asserted in SHIFT or DONE SHALL abort the operation; no result SHALL be emitted for it after deassertion.
REQ-027 The first accept SHALL be possible at the first rising edge after rst_n deasserts.

Verification (WIDTH=32, SHAMT_W=5, STEP=4)
REQ-028 Bench SHALL check each scenario below:
- SLL, in_data=0x00000001, in_shamt=2 -> out_data=0x00000004; out_valid rises 1 edge after accept.
- SRA, in_data=0x80000000, in_shamt=31 -> out_data=0xFFFFFFFF after 8 edges; in_ready=0 throughout.
- ROL, in_data=0x80000001, in_shamt=4 -> out_data=0x00000018 after 1 edge.
- SRL, in_data=0xDEADBEEF, in_shamt=0 -> out_data=0xDEADBEEF; out_valid high at the edge after accept.
- Backpressure: out_ready=0 for 3 cycles in DONE -> out_valid=1 and out_data unchanged for 3 cycles; in_ready=0; the next accept occurs only after the consume edge plus one.
- Reset: rst_n pulled low mid-SHIFT (SLL 0xFFFFFFFF, shamt 20) -> immediately out_valid=0, out_data=0, in_ready=1; no stray out_valid after release.
